// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - recovers pixel position and lock status from strobed VGA hsync/vsync
// Timing is learned from the incoming syncs; lock needs LOCK_FRAMES identical frames.
module vga_sync_receiver #(
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_en,
    input  logic       i_hsync,
    input  logic       i_vsync,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_active,
    output logic       o_locked,
    output logic [9:0] o_line_len,
    output logic [9:0] o_frame_lines,
    output logic       o_err
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [10:0] LP_H_LO   = 11'(H_BACK);
    localparam logic [10:0] LP_H_HI   = 11'(H_BACK + H_ACTIVE);
    localparam logic [10:0] LP_V_LO   = 11'(V_BACK);
    localparam logic [10:0] LP_V_HI   = 11'(V_BACK + V_ACTIVE);
    localparam logic [9:0]  LP_H_OFS  = 10'(H_BACK);
    localparam logic [9:0]  LP_V_OFS  = 10'(V_BACK);
    localparam logic [7:0]  LP_LOCK   = 8'(LOCK_FRAMES);
    localparam logic [9:0]  LP_WD_MAX = 10'd1022;

    state_t     r_state;
    logic       r_hs_q;
    logic       r_vs_q;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [9:0] r_wd_cnt;
    logic [9:0] r_line_len;
    logic [9:0] r_frame_lines;
    logic [7:0] r_match_cnt;
    logic       r_frame_ok;
    logic       r_locked;
    logic       r_err;

    logic       w_h_edge;
    logic       w_v_edge;
    logic       w_h_max;
    logic       w_v_max;
    logic [9:0] w_line_meas;
    logic [9:0] w_frame_meas;
    logic       w_line_mis;
    logic       w_frame_mis;
    logic       w_frame_match;
    logic       w_wd_fire;
    logic [7:0] w_match_inc;
    logic       w_h_in;
    logic       w_v_in;
    logic       w_active;

    // Deassert edge compares the live input with the sample from the previous strobe.
    assign w_h_edge = i_pix_en & ~r_hs_q & i_hsync;
    assign w_v_edge = i_pix_en & ~r_vs_q & i_vsync;

    assign w_h_max      = (r_h_cnt == 10'h3FF);
    assign w_v_max      = (r_v_cnt == 10'h3FF);
    assign w_line_meas  = w_h_max ? 10'h3FF : r_h_cnt + 10'd1;
    assign w_frame_meas = w_v_max ? 10'h3FF : r_v_cnt + 10'd1;

    assign w_line_mis    = w_h_edge && (w_line_meas != r_line_len);
    assign w_frame_mis   = w_v_edge && (w_frame_meas != r_frame_lines);
    assign w_frame_match = r_frame_ok && !w_line_mis && !w_frame_mis;
    assign w_match_inc   = (r_match_cnt == 8'hFF) ? 8'hFF : r_match_cnt + 8'd1;

    // 1023rd consecutive strobe without a line start.
    assign w_wd_fire = i_pix_en && !w_h_edge && (r_wd_cnt == LP_WD_MAX);

    assign w_h_in   = ({1'b0, r_h_cnt} >= LP_H_LO) && ({1'b0, r_h_cnt} < LP_H_HI);
    assign w_v_in   = ({1'b0, r_v_cnt} >= LP_V_LO) && ({1'b0, r_v_cnt} < LP_V_HI);
    assign w_active = w_h_in && w_v_in && r_locked;

    assign o_active      = w_active;
    assign o_x           = w_active ? r_h_cnt - LP_H_OFS : 10'd0;
    assign o_y           = w_active ? r_v_cnt - LP_V_OFS : 10'd0;
    assign o_locked      = r_locked;
    assign o_line_len    = r_line_len;
    assign o_frame_lines = r_frame_lines;
    assign o_err         = r_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= SEARCH;
            r_hs_q        <= 1'b1;
            r_vs_q        <= 1'b1;
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_wd_cnt      <= 10'd0;
            r_line_len    <= 10'd0;
            r_frame_lines <= 10'd0;
            r_match_cnt   <= 8'd0;
            r_frame_ok    <= 1'b0;
            r_locked      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (i_pix_en) begin
                r_hs_q <= i_hsync;
                r_vs_q <= i_vsync;

                if (w_h_edge) begin
                    r_h_cnt <= 10'd0;
                end else if (!w_h_max) begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end

                if (w_v_edge) begin
                    r_v_cnt <= 10'd0;
                end else if (w_h_edge && !w_v_max) begin
                    r_v_cnt <= r_v_cnt + 10'd1;
                end

                if (w_h_edge || w_wd_fire) begin
                    r_wd_cnt <= 10'd0;
                end else begin
                    r_wd_cnt <= r_wd_cnt + 10'd1;
                end

                if (w_h_edge) begin
                    r_line_len <= w_line_meas;
                end
                if (w_v_edge) begin
                    r_frame_lines <= w_frame_meas;
                end

                if (w_wd_fire) begin
                    r_err       <= (r_state == LOCKED);
                    r_state     <= SEARCH;
                    r_locked    <= 1'b0;
                    r_match_cnt <= 8'd0;
                    r_frame_ok  <= 1'b0;
                end else begin
                    case (r_state)
                        SEARCH: begin
                            if (w_v_edge) begin
                                r_state     <= MEASURE;
                                r_match_cnt <= 8'd0;
                                r_frame_ok  <= 1'b1;
                            end
                        end
                        MEASURE: begin
                            // A frame closes on its vsync edge; the coincident line edge still belongs to it.
                            if (w_v_edge) begin
                                r_frame_ok <= 1'b1;
                                if (w_frame_match) begin
                                    r_match_cnt <= w_match_inc;
                                    if (w_match_inc >= LP_LOCK) begin
                                        r_state  <= LOCKED;
                                        r_locked <= 1'b1;
                                    end
                                end else begin
                                    r_match_cnt <= 8'd0;
                                end
                            end else if (w_line_mis) begin
                                r_frame_ok <= 1'b0;
                            end
                        end
                        LOCKED: begin
                            if (w_line_mis || w_frame_mis) begin
                                r_err       <= 1'b1;
                                r_locked    <= 1'b0;
                                r_state     <= MEASURE;
                                r_match_cnt <= 8'd0;
                                r_frame_ok  <= w_v_edge;
                            end
                        end
                        default: begin
                            r_state  <= SEARCH;
                            r_locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - scoreboard bench for vga_sync_receiver on a reduced 40x20 raster
module tb_vga_sync_receiver;

    localparam int HB = 6;
    localparam int HA = 24;
    localparam int VB = 3;
    localparam int VA = 12;
    localparam int LF = 2;
    localparam int L  = 40;
    localparam int HS = 4;
    localparam int F  = 20;
    localparam int VS = 2;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_pix_en;
    logic       i_hsync;
    logic       i_vsync;
    logic [9:0] o_x;
    logic [9:0] o_y;
    logic       o_active;
    logic       o_locked;
    logic [9:0] o_line_len;
    logic [9:0] o_frame_lines;
    logic       o_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       act;
        logic [9:0] x;
        logic [9:0] y;
        logic       lk;
        logic       err;
        logic       chk;
        logic [9:0] ll;
        logic [9:0] fl;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_pix_en(i_pix_en), .i_hsync(i_hsync), .i_vsync(i_vsync),
        .o_x(o_x), .o_y(o_y), .o_active(o_active), .o_locked(o_locked),
        .o_line_len(o_line_len), .o_frame_lines(o_frame_lines), .o_err(o_err)
    );

    // Three idle cycles with junk on the syncs, then one strobe; returns 1ns after its edge.
    task automatic drive_strobe(input logic hs, input logic vs);
        repeat (3) begin
            @(negedge clk);
            i_pix_en = 1'b0;
            i_hsync  = 1'($urandom);
            i_vsync  = 1'($urandom);
        end
        @(negedge clk);
        i_pix_en = 1'b1;
        i_hsync  = hs;
        i_vsync  = vs;
        @(posedge clk);
        #1;
        i_pix_en = 1'b0;
    endtask

    task automatic send_frame(input bit lk0, input int long_line, input bit chk_meas);
        exp_t e;
        exp_t g;
        int   len;
        for (int l = 0; l < F; l++) begin
            len = (l == long_line) ? L + 1 : L;
            for (int p = 0; p < len; p++) begin
                e.lk  = lk0 && !(long_line >= 0 && l > long_line);
                e.act = e.lk && p >= HB && p < HB + HA && l >= VB && l < VB + VA;
                e.x   = e.act ? 10'(p - HB) : 10'd0;
                e.y   = e.act ? 10'(l - VB) : 10'd0;
                e.err = lk0 && long_line >= 0 && l == long_line + 1 && p == 0;
                e.chk = chk_meas;
                e.ll  = (l >= 1 && l - 1 == long_line) ? 10'(L + 1) : 10'(L);
                e.fl  = 10'(F);
                sb.push_back(e);
                drive_strobe(p < len - HS, l < F - VS);
                g = sb.pop_front();
                n_tests++;
                if ({o_active, o_x, o_y, o_locked, o_err} !== {g.act, g.x, g.y, g.lk, g.err} ||
                    (g.chk && {o_line_len, o_frame_lines} !== {g.ll, g.fl})) begin
                    n_fail++;
                    $display("FAIL frame_pix l=%0d p=%0d got act=%b x=%0d y=%0d lk=%b err=%b ll=%0d fl=%0d exp act=%b x=%0d y=%0d lk=%b err=%b ll=%0d fl=%0d",
                             l, p, o_active, o_x, o_y, o_locked, o_err, o_line_len, o_frame_lines,
                             g.act, g.x, g.y, g.lk, g.err, g.ll, g.fl);
                end
                if (g.err) begin
                    @(posedge clk);
                    #1;
                    n_tests++;
                    if (o_err !== 1'b0) begin
                        n_fail++;
                        $display("FAIL err_width got o_err=%b exp 0", o_err);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            i_rst    = 1'b0;
            i_pix_en = 1'($urandom);
            i_hsync  = 1'($urandom);
            i_vsync  = 1'($urandom);
            @(posedge clk);
            #1;
            n_tests++;
            if ({o_x, o_y, o_active, o_locked, o_line_len, o_frame_lines, o_err} !== 43'd0) begin
                n_fail++;
                $display("FAIL reset_state got x=%0d y=%0d act=%b lk=%b ll=%0d fl=%0d err=%b exp all 0",
                         o_x, o_y, o_active, o_locked, o_line_len, o_frame_lines, o_err);
            end
        end
        @(negedge clk);
        i_rst    = 1'b1;
        i_pix_en = 1'b0;
        i_hsync  = 1'b1;
        i_vsync  = 1'b1;
    endtask

    task automatic test_lock();
        send_frame(1'b0, -1, 1'b0);
        send_frame(1'b0, -1, 1'b1);
        send_frame(1'b0, -1, 1'b1);
        send_frame(1'b1, -1, 1'b1);
    endtask

    task automatic test_line_error();
        send_frame(1'b1, 5, 1'b1);
        send_frame(1'b0, -1, 1'b1);
        send_frame(1'b0, -1, 1'b1);
        send_frame(1'b1, -1, 1'b1);
    endtask

    task automatic test_watchdog();
        exp_t e;
        exp_t g;
        for (int k = 0; k <= 1100; k++) begin
            e.act = 1'b0;
            e.x   = 10'd0;
            e.y   = 10'd0;
            e.lk  = (k < 1023);
            e.err = (k == 1023);
            e.chk = 1'b0;
            e.ll  = 10'd0;
            e.fl  = 10'd0;
            sb.push_back(e);
            drive_strobe(1'b1, 1'b1);
            g = sb.pop_front();
            n_tests++;
            if ({o_active, o_x, o_y, o_locked, o_err} !== {g.act, g.x, g.y, g.lk, g.err}) begin
                n_fail++;
                $display("FAIL watchdog k=%0d got act=%b x=%0d y=%0d lk=%b err=%b exp act=%b lk=%b err=%b",
                         k, o_active, o_x, o_y, o_locked, o_err, g.act, g.lk, g.err);
            end
            if (g.err) begin
                @(posedge clk);
                #1;
                n_tests++;
                if (o_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL watchdog_err_width got o_err=%b exp 0", o_err);
                end
            end
        end
        test_lock();
    endtask

    task automatic test_reset_locked();
        for (int l = 0; l <= VB + 1; l++) begin
            for (int p = 0; p < ((l == VB + 1) ? HB + 3 : L); p++) begin
                drive_strobe(p < L - HS, l < F - VS);
            end
        end
        n_tests++;
        if ({o_active, o_x, o_y, o_locked} !== {1'b1, 10'd2, 10'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset_active got act=%b x=%0d y=%0d lk=%b exp act=1 x=2 y=1 lk=1",
                     o_active, o_x, o_y, o_locked);
        end
        @(negedge clk);
        i_rst    = 1'b0;
        i_pix_en = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if ({o_x, o_y, o_active, o_locked, o_line_len, o_frame_lines, o_err} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_locked got x=%0d y=%0d act=%b lk=%b ll=%0d fl=%0d err=%b exp all 0",
                     o_x, o_y, o_active, o_locked, o_line_len, o_frame_lines, o_err);
        end
        @(negedge clk);
        i_rst   = 1'b1;
        i_hsync = 1'b1;
        i_vsync = 1'b1;
        test_lock();
    endtask

    initial begin
        i_rst    = 1'b0;
        i_pix_en = 1'b0;
        i_hsync  = 1'b1;
        i_vsync  = 1'b1;
        test_reset();
        test_lock();
        test_line_error();
        test_watchdog();
        test_reset_locked();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameter H_BACK, default 48, pixels from hsync deassert to first active pixel.
REQ-002 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-003 SHALL have parameter V_BACK, default 33, lines from vsync deassert to first active line.
REQ-004 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, consecutive matching frames required for lock.
REQ-006 SHALL have port i_clk  input  1  system clock (100MHz onboard).
REQ-007 SHALL have port i_rst  input  1  reset; synchronous, active-low.
REQ-008 SHALL have port i_pix_en  input  1  pixel strobe; one pixel per cycle with i_pix_en=1.
REQ-009 SHALL have port i_hsync  input  1  horizontal sync, active-low.
REQ-010 SHALL have port i_vsync  input  1  vertical sync, active-low.
REQ-011 SHALL have port o_x  output  10  recovered pixel x; 0 outside active.
REQ-012 SHALL have port o_y  output  10  recovered pixel y; 0 outside active.
REQ-013 SHALL have port o_active  output  1  high when h and v position are both inside the active window.
REQ-014 SHALL have port o_locked  output  1  high while timing is stable.
REQ-015 SHALL have port o_line_len  output  10  last measured pixels per line.
REQ-016 SHALL have port o_frame_lines  output  10  last measured lines per frame.
REQ-017 SHALL have port o_err  output  1  one-cycle pulse on loss of lock or watchdog timeout.

Function
REQ-018 All state SHALL advance only on i_clk edges with i_pix_en=1, except o_err clearing, which happens on the next i_clk edge.
REQ-019 hsync/vsync SHALL be registered on each strobe; a deassert edge is previous sample 0 and current sample 1.
REQ-020 h_cnt SHALL become 0 on an hsync deassert edge; otherwise it increments by 1 and saturates at 1023.
REQ-021 v_cnt SHALL become 0 on a vsync deassert edge; otherwise it increments on each hsync deassert edge and saturates at 1023; a simultaneous vsync edge takes priority.
REQ-022 o_active SHALL be 1 iff H_BACK <= h_cnt < H_BACK+H_ACTIVE and V_BACK <= v_cnt < V_BACK+V_ACTIVE, and o_locked=1.
REQ-023 o_x SHALL equal h_cnt-H_BACK and o_y SHALL equal v_cnt-V_BACK when o_active=1; both SHALL be 0 otherwise.
REQ-024 On each hsync deassert edge, line length SHALL be h_cnt+1 (saturated at 1023), and it SHALL be compared with the stored o_line_len before o_line_len is updated.
REQ-025 On each vsync deassert edge, frame lines SHALL be v_cnt+1 (saturated), compared with the stored value, and then stored in o_frame_lines.
REQ-026 The FSM SHALL have states SEARCH, MEASURE and LOCKED.
REQ-027 SEARCH SHALL go to MEASURE on the first vsync deassert edge, with match count 0.
REQ-028 In MEASURE, a frame SHALL match if every line length and the frame line count equal the stored values; a match increments the match count and a mismatch clears it to 0.
REQ-029 MEASURE SHALL go to LOCKED when the match count reaches LOCK_FRAMES, and o_locked SHALL rise on that same edge.
REQ-030 In LOCKED, any line length or frame line mismatch SHALL pulse o_err, drop o_locked, go to MEASURE and clear the match count.
REQ-031 Watchdog: if 1023 consecutive strobes pass with no hsync deassert edge, the FSM SHALL go to SEARCH from any state; o_err SHALL pulse if the FSM was LOCKED; o_locked SHALL drop.
REQ-032 The watchdog counter SHALL clear on every hsync deassert edge and on reset.

Reset
REQ-033 With i_rst=0 at an i_clk edge, regardless of i_pix_en: FSM=SEARCH, all counters=0, sync registers=1, and o_x, o_y, o_active, o_locked, o_line_len, o_frame_lines and o_err all = 0.
REQ-034 Reset asserted mid-frame while LOCKED SHALL apply REQ-033 on that edge, with no o_err pulse.

Verification
REQ-035 Send standard 800x525 timing (hsync 96 low, vsync 2 lines low), strobe every 4th clock -> o_locked=1 at the vsync deassert edge ending the third frame (REQ-027, REQ-029), o_line_len=800, o_frame_lines=525.
REQ-036 When locked -> o_active first high with o_x=0, o_y=0 at h_cnt=48, v_cnt=33; o_x=639 at the last active pixel, and o_active low on the next strobe.
REQ-037 When locked, send one line of 801 pixels -> o_err pulses exactly 1 clock, o_locked=0, and lock returns after 2 clean frames.
REQ-038 When locked, hold hsync high for 1100 strobes -> o_err pulse at strobe 1023, FSM=SEARCH, o_active=0.
REQ-039 Assert i_rst=0 mid-line while locked -> all outputs 0 on the next edge, no o_err; first vsync deassert after release goes to MEASURE.
REQ-040 Drive hsync and vsync deassert on the same strobe -> v_cnt=0, not 1.
